// File: rtl/aes_pkg.sv
// Shared AES definitions: GF(2^8) reduction polynomial, xtime helper and
// the state encoding used by the column-mixing controller.
package aes_pkg;

    localparam logic [8:0] AES_POLY = 9'h11B;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } mc_state_t;

    // Multiply by x in GF(2^8), reducing by the AES polynomial.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? AES_POLY[7:0] : 8'h00);
    endfunction

endpackage

// File: rtl/mix_column_core.sv
// Combinational MixColumns / InvMixColumns on one 32-bit column.
// Row 0 byte sits in the MSB; shared by encrypt and decrypt round datapaths.
module mix_column_core
    import aes_pkg::*;
(
    input  logic [31:0] i_col,
    input  logic        i_inv,
    output logic [31:0] o_col
);

    logic [7:0] w_a  [4];
    logic [7:0] w_a2 [4];
    logic [7:0] w_a4 [4];
    logic [7:0] w_a8 [4];
    logic [7:0] w_m0 [4];
    logic [7:0] w_m1 [4];
    logic [7:0] w_m2 [4];
    logic [7:0] w_m3 [4];

    // m0..m3 are the products with the first-row coefficients:
    // forward {02,03,01,01}, inverse {0e,0b,0d,09}, built from xtime chains.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            w_a[i]  = i_col[31-8*i -: 8];
            w_a2[i] = xtime(w_a[i]);
            w_a4[i] = xtime(w_a2[i]);
            w_a8[i] = xtime(w_a4[i]);
            w_m0[i] = i_inv ? (w_a8[i] ^ w_a4[i] ^ w_a2[i]) : w_a2[i];
            w_m1[i] = i_inv ? (w_a8[i] ^ w_a2[i] ^ w_a[i])  : (w_a2[i] ^ w_a[i]);
            w_m2[i] = i_inv ? (w_a8[i] ^ w_a4[i] ^ w_a[i])  : w_a[i];
            w_m3[i] = i_inv ? (w_a8[i] ^ w_a[i])            : w_a[i];
        end
    end

    assign o_col[31:24] = w_m0[0] ^ w_m1[1] ^ w_m2[2] ^ w_m3[3];
    assign o_col[23:16] = w_m0[1] ^ w_m1[2] ^ w_m2[3] ^ w_m3[0];
    assign o_col[15:8]  = w_m0[2] ^ w_m1[3] ^ w_m2[0] ^ w_m3[1];
    assign o_col[7:0]   = w_m0[3] ^ w_m1[0] ^ w_m2[1] ^ w_m3[2];

endmodule

// File: rtl/mix_columns_engine.sv
// Iterative AES (Inv)MixColumns engine: LANES columns per BUSY cycle,
// valid/ready on both sides, optional registered output stage.
//
//   state | meaning
//   IDLE  | waiting for a block, in_ready high
//   BUSY  | transforming columns in place, col advances by LANES
//   DONE  | result presented until the consumer takes it
module mix_columns_engine
    import aes_pkg::*;
#(
    parameter int LANES   = 1,
    parameter bit OUT_REG = 1'b0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] data_in,
    input  logic         inv,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] data_out,
    output logic         busy
);

    if (LANES != 1 && LANES != 2 && LANES != 4) begin : g_bad_lanes
        $error("mix_columns_engine: LANES must be 1, 2 or 4");
    end

    localparam logic [1:0] COL_STEP = LANES[1:0];
    localparam logic [1:0] LAST_COL = 2'(4 - LANES);

    mc_state_t     r_fsm;
    mc_state_t     w_fsm_nxt;
    logic [127:0]  r_blk;
    logic          r_inv;
    logic [1:0]    r_col;

    logic          w_accept;
    logic          w_out_fire;
    logic          w_last;
    logic [127:0]  w_blk_step;
    logic [31:0]   w_cols     [4];
    logic [31:0]   w_cols_nxt [4];
    logic [1:0]    w_idx      [LANES];
    logic [31:0]   w_lane_in  [LANES];
    logic [31:0]   w_lane_out [LANES];

    assign w_out_fire = out_valid & out_ready;
    assign in_ready   = (r_fsm == ST_IDLE) | ((r_fsm == ST_DONE) & w_out_fire);
    assign w_accept   = in_valid & in_ready;
    assign w_last     = (r_col == LAST_COL);
    assign busy       = (r_fsm == ST_BUSY);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fsm <= ST_IDLE;
        end else begin
            r_fsm <= w_fsm_nxt;
        end
    end

    always_comb begin
        w_fsm_nxt = r_fsm;
        case (r_fsm)
            ST_IDLE: if (in_valid) w_fsm_nxt = ST_BUSY;
            ST_BUSY: if (w_last) w_fsm_nxt = ST_DONE;
            ST_DONE: if (w_out_fire) w_fsm_nxt = in_valid ? ST_BUSY : ST_IDLE;
            default: w_fsm_nxt = ST_IDLE;
        endcase
    end

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        assign w_idx[g]     = r_col + 2'(g);
        assign w_lane_in[g] = w_cols[w_idx[g]];
        mix_column_core u_core (
            .i_col (w_lane_in[g]),
            .i_inv (r_inv),
            .o_col (w_lane_out[g])
        );
    end

    // Only the columns handled by a lane this cycle change; the rest pass through.
    always_comb begin
        for (int c = 0; c < 4; c++) begin
            w_cols[c]     = r_blk[127-32*c -: 32];
            w_cols_nxt[c] = w_cols[c];
        end
        for (int g = 0; g < LANES; g++) begin
            w_cols_nxt[w_idx[g]] = w_lane_out[g];
        end
        w_blk_step = '0;
        for (int c = 0; c < 4; c++) begin
            w_blk_step[127-32*c -: 32] = w_cols_nxt[c];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_blk <= '0;
            r_inv <= 1'b0;
            r_col <= 2'd0;
        end else if (w_accept) begin
            r_blk <= data_in;
            r_inv <= inv;
            r_col <= 2'd0;
        end else if (r_fsm == ST_BUSY) begin
            r_blk <= w_blk_step;
            r_col <= r_col + COL_STEP;
        end
    end

    if (OUT_REG) begin : g_out_reg
        logic         r_out_valid;
        logic [127:0] r_data_out;

        // The result is copied into the output stage on the first DONE cycle,
        // so valid rises one cycle later and holds until taken.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_out_valid <= 1'b0;
                r_data_out  <= '0;
            end else begin
                r_out_valid <= (r_fsm == ST_DONE) & ~w_out_fire;
                if ((r_fsm == ST_DONE) && !r_out_valid) begin
                    r_data_out <= r_blk;
                end
            end
        end

        assign out_valid = r_out_valid;
        assign data_out  = r_data_out;
    end else begin : g_out_comb
        assign out_valid = (r_fsm == ST_DONE);
        assign data_out  = r_blk;
    end

endmodule
